// File: rtl/aes_arb_pkg.sv
// Shared types for the AES cipher-text arbiter: FSM state, counter width, 4x4 byte block.
package aes_arb_pkg;
  typedef enum logic {ARB, SEND} aes_arb_state_t;
  localparam int AES_ARB_CNT_W = 16;
  typedef logic [3:0][3:0][7:0] aes_block_t;
endpackage

// File: rtl/aes_rr_picker.sv
// Combinational round-robin picker: first vld above last_grant, wrapping modulo N.
// No latency, no state; the caller decides when the pick is used.
module aes_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vld,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  int             sel;

  // Lower half holds requesters above last_grant, upper half the wrapped set;
  // the lowest set bit of the doubled vector is the round-robin winner.
  always_comb begin
    for (int i = 0; i < N; i++) mask[i] = (i > int'(last_grant));
    dbl = {vld, vld & mask};
    sel = 0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) sel = i;
    end
    grant_idx = IW'(sel % N);
    for (int i = 0; i < N; i++) grant[i] = (|vld) && ((sel % N) == i);
  end
endmodule

// File: rtl/aes_cipher_txt_arbiter.sv
// Round-robin share of one cipher-text write port among NUM_REQ AES cores; AES_ARB_STATS_EN adds per-core block counters.
// 1-cycle accept-to-present; cipher_txt_rdy low holds the block and forces every req_cipher_rdy low.
module aes_cipher_txt_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NO_ROWS   = 4,
  parameter int NO_COLS   = 4,
  parameter int MAX_BURST = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                          aes_clk,
  input  logic                                          resetn,
  input  logic [NUM_REQ-1:0]                            req_cipher_vld,
  output logic [NUM_REQ-1:0]                            req_cipher_rdy,
  input  logic [NUM_REQ-1:0][NO_ROWS-1:0][NO_COLS-1:0][7:0] req_cipher_txt,
  output logic                                          cipher_txt_vld,
  input  logic                                          cipher_txt_rdy,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]          aes_cipher_txt,
  output logic [IW-1:0]                                 grant_id,
`ifdef AES_ARB_STATS_EN
  input  logic                                          stats_clr,
  output logic [NUM_REQ-1:0][AES_ARB_CNT_W-1:0]         blk_cnt,
`endif
  output logic                                          busy
);
  localparam int BW = 8;

  aes_arb_state_t state;
  logic [IW-1:0]  last_grant;
  logic [BW-1:0]  burst_cnt;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]  pick_idx;
  logic [IW-1:0]  src_idx;
  logic           chain_ok;
  logic           accept;

  aes_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
    .vld        (req_cipher_vld),
    .last_grant (last_grant),
    .grant      (pick_oh),
    .grant_idx  (pick_idx)
  );

  assign chain_ok = cipher_txt_rdy && (burst_cnt < BW'(MAX_BURST));
  assign src_idx  = (state == ARB) ? pick_idx : grant_id;
  assign accept   = |(req_cipher_vld & req_cipher_rdy);

  always_comb begin
    req_cipher_rdy = '0;
    if (resetn) begin
      if (state == ARB) begin
        req_cipher_rdy = pick_oh;
      end else begin
        for (int i = 0; i < NUM_REQ; i++)
          req_cipher_rdy[i] = chain_ok && (grant_id == IW'(i));
      end
    end
  end

  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      state          <= ARB;
      cipher_txt_vld <= 1'b0;
      busy           <= 1'b0;
      aes_cipher_txt <= '0;
      grant_id       <= '0;
      last_grant     <= IW'(NUM_REQ-1);
      burst_cnt      <= '0;
    end else begin
      case (state)
        ARB: begin
          if (|req_cipher_vld) begin
            aes_cipher_txt <= req_cipher_txt[src_idx];
            grant_id       <= pick_idx;
            burst_cnt      <= BW'(1);
            cipher_txt_vld <= 1'b1;
            busy           <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          if (cipher_txt_rdy) begin
            if (accept) begin
              aes_cipher_txt <= req_cipher_txt[src_idx];
              burst_cnt      <= burst_cnt + BW'(1);
            end else begin
              last_grant     <= grant_id;
              cipher_txt_vld <= 1'b0;
              busy           <= 1'b0;
              state          <= ARB;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

`ifdef AES_ARB_STATS_EN
  // Clear has priority over a transfer in the same cycle.
  always_ff @(posedge aes_clk or negedge resetn) begin
    if (!resetn) begin
      blk_cnt <= '0;
    end else if (stats_clr) begin
      blk_cnt <= '0;
    end else if (cipher_txt_vld && cipher_txt_rdy && (blk_cnt[grant_id] != '1)) begin
      blk_cnt[grant_id] <= blk_cnt[grant_id] + AES_ARB_CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_aes_cipher_txt_arbiter.sv
// Bench for aes_cipher_txt_arbiter: rule-level arbitration model, in-order block scoreboard, directed scenarios.
`timescale 1ns/1ps
module tb_aes_cipher_txt_arbiter;
  import aes_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXB = 2;

  logic                      aes_clk = 1'b0;
  logic                      resetn  = 1'b0;
  logic [N-1:0]              req_cipher_vld = '0;
  logic [N-1:0]              req_cipher_rdy;
  logic [N-1:0][3:0][3:0][7:0] req_cipher_txt = '0;
  logic                      cipher_txt_vld;
  logic                      cipher_txt_rdy = 1'b1;
  aes_block_t                aes_cipher_txt;
  logic [1:0]                grant_id;
  logic                      busy;
`ifdef AES_ARB_STATS_EN
  logic                      stats_clr = 1'b0;
  logic [N-1:0][15:0]        blk_cnt;
`endif

  aes_cipher_txt_arbiter #(.NUM_REQ(N), .NO_ROWS(4), .NO_COLS(4), .MAX_BURST(MAXB)) dut (
    .aes_clk        (aes_clk),
    .resetn         (resetn),
    .req_cipher_vld (req_cipher_vld),
    .req_cipher_rdy (req_cipher_rdy),
    .req_cipher_txt (req_cipher_txt),
    .cipher_txt_vld (cipher_txt_vld),
    .cipher_txt_rdy (cipher_txt_rdy),
    .aes_cipher_txt (aes_cipher_txt),
    .grant_id       (grant_id),
`ifdef AES_ARB_STATS_EN
    .stats_clr      (stats_clr),
    .blk_cnt        (blk_cnt),
`endif
    .busy           (busy)
  );

  always #5 aes_clk = ~aes_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_xfer = 0;
  int xfer_ids[$];
  int xfer_cyc[$];

  always @(posedge aes_clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic aes_block_t make_blk(input logic [7:0] b);
    aes_block_t r;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        r[rr][cc] = b + 8'(rr*4 + cc);
    return r;
  endfunction

  // Requester side: each core presents the head of its queue until handshaken.
  aes_block_t   q_blk[N][$];
  logic [N-1:0] hs = '0;

  always @(posedge aes_clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i] && q_blk[i].size() > 0) q_blk[i].delete(0);
      req_cipher_vld[i] = (q_blk[i].size() > 0);
      req_cipher_txt[i] = (q_blk[i].size() > 0) ? q_blk[i][0] : '0;
    end
  end

  // Model: is a block held, what it is, who sent it, how many in this grant.
  bit         m_hold = 1'b0;
  aes_block_t m_blk  = '0;
  int         m_gid  = 0;
  int         m_last = N-1;
  int         m_run  = 0;
  int         m_cnt[N];

  typedef struct packed {
    logic [1:0] id;
    aes_block_t blk;
  } sb_t;
  sb_t sb[$];

  function automatic int winner();
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (req_cipher_vld[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] r;
    int w;
    r = '0;
    if (resetn) begin
      if (!m_hold) begin
        w = winner();
        if (w >= 0) r[w] = 1'b1;
      end else if (cipher_txt_rdy && m_run < MAXB) begin
        r[m_gid] = 1'b1;
      end
    end
    return r;
  endfunction

  always @(negedge aes_clk) begin
    int w;
    sb_t s;
    if (!resetn) begin
      m_hold = 1'b0; m_blk = '0; m_gid = 0; m_last = N-1; m_run = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      sb.delete();
    end
    chk("req_cipher_rdy", req_cipher_rdy, exp_rdy());
    chk("cipher_txt_vld", cipher_txt_vld, m_hold);
    chk("busy", busy, m_hold);
    chk("aes_cipher_txt", aes_cipher_txt, m_blk);
    chk("grant_id", grant_id, m_gid);
`ifdef AES_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("blk_cnt", blk_cnt[i], m_cnt[i]);
`endif
    hs = req_cipher_vld & req_cipher_rdy;
    if (resetn) begin
      if (cipher_txt_vld && cipher_txt_rdy) begin
        if (sb.size() > 0) begin
          s = sb.pop_front();
          chk("sb_id", grant_id, s.id);
          chk("sb_data", aes_cipher_txt, s.blk);
        end else begin
          tests++; fails++;
          $display("FAIL sb_order: transfer of %0h from core %0d with no accepted block pending", aes_cipher_txt, grant_id);
        end
        n_xfer++;
        xfer_ids.push_back(int'(grant_id));
        xfer_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          s.id  = 2'(i);
          s.blk = req_cipher_txt[i];
          sb.push_back(s);
        end
      end
`ifdef AES_ARB_STATS_EN
      if (stats_clr) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (m_hold && cipher_txt_rdy && m_cnt[m_gid] < 65535) begin
        m_cnt[m_gid]++;
      end
`endif
      if (!m_hold) begin
        w = winner();
        if (w >= 0) begin
          m_hold = 1'b1; m_blk = req_cipher_txt[w]; m_gid = w; m_run = 1;
        end
      end else if (cipher_txt_rdy) begin
        if (m_run < MAXB && req_cipher_vld[m_gid]) begin
          m_blk = req_cipher_txt[m_gid];
          m_run++;
        end else begin
          m_hold = 1'b0;
          m_last = m_gid;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aes_clk); #2;
    end
  endtask

  task automatic wait_vld(input string nm);
    for (int k = 0; k < 50; k++) begin
      @(negedge aes_clk);
      if (cipher_txt_vld) break;
    end
    chk(nm, cipher_txt_vld, 1'b1);
  endtask

  task automatic wait_xfers(input string nm, input int target);
    for (int k = 0; k < 500; k++) begin
      @(posedge aes_clk); #2;
      if (n_xfer >= target) break;
    end
    chk(nm, n_xfer, target);
  endtask

  int exp_ord[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int n0;

  initial begin
    repeat (3) @(posedge aes_clk);
    #2;
    chk("rst_vld", cipher_txt_vld, 1'b0);
    chk("rst_data", aes_cipher_txt, '0);
    chk("rst_gid", grant_id, 2'd0);
    chk("rst_busy", busy, 1'b0);
    resetn = 1'b1;
    idle(2);

    // All four cores busy: rotation with bursts of two and one bubble per grant.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 3; j++)
        q_blk[i].push_back(make_blk(8'(128 + 16*i + 4*j)));
    wait_xfers("rr_xfers", 12);
    chk("rr_count", xfer_ids.size(), 12);
    for (int k = 0; k < 9 && k < xfer_ids.size(); k++) chk("rr_order", xfer_ids[k], exp_ord[k]);
    if (xfer_cyc.size() >= 9) chk("rr_span", xfer_cyc[8] - xfer_cyc[0], 12);
    idle(3);

    // Single core 2 with bytes 0x00..0x0F.
    q_blk[2].push_back(make_blk(8'h00));
    for (int k = 0; k < 20; k++) begin
      @(negedge aes_clk);
      if (req_cipher_vld[2]) break;
    end
    chk("single_rdy", req_cipher_rdy, 4'b0100);
    @(posedge aes_clk); #2;
    chk("single_vld", cipher_txt_vld, 1'b1);
    chk("single_gid", grant_id, 2'd2);
    chk("single_data", aes_cipher_txt, 128'h0f0e0d0c0b0a09080706050403020100);
    wait_xfers("single_xfer", 13);
    idle(3);

    // Downstream backpressure for ten cycles.
    cipher_txt_rdy = 1'b0;
    q_blk[1].push_back(make_blk(8'h40));
    wait_vld("bp_vld");
    n0 = n_xfer;
    for (int k = 0; k < 10; k++) begin
      chk("bp_rdy", req_cipher_rdy, 4'b0000);
      chk("bp_data", aes_cipher_txt, make_blk(8'h40));
      @(negedge aes_clk);
    end
    @(posedge aes_clk); #2;
    cipher_txt_rdy = 1'b1;
    @(posedge aes_clk); #2;
    chk("bp_one_xfer", n_xfer, n0 + 1);
    chk("bp_exit_vld", cipher_txt_vld, 1'b0);
    idle(3);

    // Reset while core 1's block is held.
    cipher_txt_rdy = 1'b0;
    q_blk[1].push_back(make_blk(8'h50));
    wait_vld("hold_vld");
    chk("hold_gid", grant_id, 2'd1);
    @(posedge aes_clk); #2;
    q_blk[0].push_back(make_blk(8'h60));
    q_blk[1].push_back(make_blk(8'h70));
    resetn = 1'b0;
    #1;
    chk("async_vld", cipher_txt_vld, 1'b0);
    chk("async_busy", busy, 1'b0);
    @(posedge aes_clk); #2;
    resetn = 1'b1;
    cipher_txt_rdy = 1'b1;
    n0 = n_xfer;
    @(negedge aes_clk);
    chk("post_rst_rdy", req_cipher_rdy, 4'b0001);
    @(posedge aes_clk); #2;
    chk("post_rst_gid", grant_id, 2'd0);
    chk("post_rst_data", aes_cipher_txt, make_blk(8'h60));
    wait_xfers("post_rst_xfers", n0 + 2);
    idle(3);

`ifdef AES_ARB_STATS_EN
    stats_clr = 1'b1;
    idle(1);
    stats_clr = 1'b0;
    n0 = n_xfer;
    for (int j = 0; j < 5; j++) q_blk[3].push_back(make_blk(8'(160 + j)));
    wait_xfers("stats_xfers", n0 + 5);
    idle(2);
    chk("stats_five", blk_cnt[3], 16'd5);
    cipher_txt_rdy = 1'b0;
    q_blk[3].push_back(make_blk(8'hB0));
    wait_vld("stats_hold_vld");
    @(posedge aes_clk); #2;
    cipher_txt_rdy = 1'b1;
    stats_clr = 1'b1;
    @(posedge aes_clk); #2;
    stats_clr = 1'b0;
    chk("stats_clr_wins", blk_cnt[3], 16'd0);
    chk("stats_sixth_xfer", n_xfer, n0 + 6);
    idle(3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/aes_cipher_txt_arbiter.md
# aes_cipher_txt_arbiter

Round-robin scheduler sharing the encryptor output buffer's single cipher-text write port between NUM_REQ AES encryption cores. Each core presents a 16-byte cipher block with a valid/ready handshake. The arbiter grants one core at a time, registers the block into a one-entry holding stage, and presents it on the buffer's cipher_txt_vld/cipher_txt_rdy/aes_cipher_txt interface. It sits in the aes_clk domain between the core array and the output buffer.

## Interface
- NUM_REQ, 4, number of requesting AES cores (1..16)
- NO_ROWS, 4, cipher state rows
- NO_COLS, 4, cipher state columns
- MAX_BURST, 2, maximum back-to-back blocks per grant before re-arbitration (1..255)
- aes_clk  input  1  sole clock; the design has one clock, aes_clk
- resetn  input  1  reset; asynchronous, active-low
- req_cipher_vld  input  [NUM_REQ]  per-core block valid
- req_cipher_rdy  output  [NUM_REQ]  per-core block accepted (combinational)
- req_cipher_txt  input  [NUM_REQ][NO_ROWS][NO_COLS] x 8  per-core cipher block
- cipher_txt_vld  output  1  held block valid toward buffer
- cipher_txt_rdy  input  1  buffer can accept a block
- aes_cipher_txt  output  [NO_ROWS][NO_COLS] x 8  held block
- grant_id  output  $clog2(NUM_REQ) (min 1)  source core of held/last block
- busy  output  1  high while in SEND
- stats_clr  input  1  clear block counters (AES_ARB_STATS_EN only)
- blk_cnt  output  [NUM_REQ] x 16  per-core forwarded-block count (AES_ARB_STATS_EN only)

## Operation
- FSM states ARB, SEND; reset state ARB.
- ARB: picker selects the first requester with vld=1, searching from last_grant+1 upward, modulo NUM_REQ. req_cipher_rdy[g]=1 for the picked g only. At the clock edge, if any vld=1: capture req_cipher_txt[g], set grant_id<=g and burst_cnt<=1, then go to SEND. If no vld=1, stay in ARB with all rdy=0.
- SEND: cipher_txt_vld=1. A transfer happens on an edge where cipher_txt_rdy=1.
- SEND chaining: req_cipher_rdy[grant_id] = cipher_txt_rdy && (burst_cnt < MAX_BURST). If that requester is valid at the transfer edge, load its next block, burst_cnt++, and stay in SEND.
- SEND exit: on a transfer edge without chaining, set last_grant<=grant_id and go to ARB.
- Protocol: requesters hold vld and data stable until rdy. Dropping vld without a handshake is illegal and is not checked.
- Outputs are registered except req_cipher_rdy. aes_cipher_txt and grant_id hold their last value outside SEND.
- Reset values: cipher_txt_vld=0, aes_cipher_txt=all zero, grant_id=0, busy=0, req_cipher_rdy=0, last_grant=NUM_REQ-1 (core 0 wins first), burst_cnt=0, blk_cnt=0.
- NUM_REQ=1: degenerates to a registered pass-through with bursts bounded by MAX_BURST.

## Timing
- Accept-to-present latency: 1 cycle. A block accepted at edge N drives cipher_txt_vld=1 after edge N.
- Sustained throughput: 1 block/cycle while chaining. Each re-arbitration costs 1 bubble cycle in ARB.
- Backpressure: cipher_txt_rdy=0 holds the block and all req_cipher_rdy low. No data is lost or duplicated.
- Simultaneous requests: strict rotation. Each valid core is granted within NUM_REQ grants.
- Reset mid-operation: the held block is discarded, the FSM returns to ARB, and cipher_txt_vld falls asynchronously.

## Configuration
- AES_ARB_STATS_EN defined:
  - stats_clr and blk_cnt ports exist.
  - blk_cnt[grant_id] increments on each downstream transfer and saturates at 16'hFFFF.
  - stats_clr=1 clears all counters at the next edge; clear wins over a same-cycle increment.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Package aes_arb_pkg holds:
  - aes_arb_state_t enum {ARB, SEND}
  - localparam AES_ARB_CNT_W=16
  - typedef aes_block_t, an 8-bit [4][4] cipher block
- Sub-module aes_rr_picker is purely combinational. Inputs: vld vector, last_grant. Outputs: one-hot grant and encoded index. Implemented with the double-width masked-priority method.

## Test plan
- Single core: core 2 valid with block 0x00..0x0F, cipher_txt_rdy=1 -> rdy[2] for 1 cycle; next cycle cipher_txt_vld=1, grant_id=2, data 0x00..0x0F.
- All four valid continuously, MAX_BURST=2, rdy=1 -> grant order 0,0,1,1,2,2,3,3,0, with one bubble between cores.
- cipher_txt_rdy=0 for 10 cycles during SEND -> block held stable, all req_cipher_rdy=0; transfer on the first rdy=1 edge.
- resetn pulsed low while in SEND with core 1's block held -> cipher_txt_vld=0 immediately; after release, core 0 wins if cores 0 and 1 are both valid.
- AES_ARB_STATS_EN: 5 blocks from core 3 -> blk_cnt[3]=5. stats_clr asserted in the same cycle as a 6th transfer -> blk_cnt[3]=0.
